// File: rtl/uart_sched_pkg.sv
// rtl/uart_sched_pkg.sv - shared constants and read-FSM state type for uart_tx_sched
package uart_sched_pkg;

    localparam int DEFAULT_DATA_SIZE = 8;
    localparam int DEFAULT_STAT_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } sched_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter, one-hot grant, pointer moves only on advance
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // 1 means channel 1 won the most recent accepted transfer, so channel 0 wins the next tie
    logic last_winner;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_winner ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_winner <= 1'b1;
        end else if (advance) begin
            last_winner <= grant[1];
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - two-channel round-robin FIFO writer and UART TX read sequencer
// Optional per-channel accepted-byte counters are built when SCHED_STATS_EN is defined.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int STAT_W    = DEFAULT_STAT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_SIZE-1:0] ch0_data,
    input  logic                 ch0_valid,
    output logic                 ch0_ready,
    input  logic [DATA_SIZE-1:0] ch1_data,
    input  logic                 ch1_valid,
    output logic                 ch1_ready,
    output logic [DATA_SIZE-1:0] fifo_din,
    output logic                 fifo_wr_en,
    input  logic                 fifo_full,
    input  logic [DATA_SIZE-1:0] fifo_dout,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    output logic                 tx_start,
    input  logic                 tx_busy,
`ifdef SCHED_STATS_EN
    output logic [STAT_W-1:0]    stat_cnt0,
    output logic [STAT_W-1:0]    stat_cnt1,
`endif
    output logic [DATA_SIZE-1:0] tx_data
);

    if (STAT_W < 1 || DATA_SIZE < 1) begin : g_param_check
        $error("uart_tx_sched: DATA_SIZE and STAT_W must be at least 1");
    end

    logic [1:0]   req;
    logic [1:0]   grant;
    logic [1:0]   accept;
    sched_state_t state;
    sched_state_t state_nxt;

    assign req = {ch1_valid, ch0_valid};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (fifo_wr_en),
        .grant   (grant)
    );

    // A full FIFO blocks the grant from completing; the arbiter pointer only moves on a real write
    assign ch0_ready  = grant[0] & ~fifo_full;
    assign ch1_ready  = grant[1] & ~fifo_full;
    assign accept     = req & {ch1_ready, ch0_ready};
    assign fifo_wr_en = |accept;
    assign fifo_din   = grant[1] ? ch1_data : ch0_data;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (!fifo_empty && !tx_busy) state_nxt = ST_LOAD;
            ST_LOAD:      state_nxt = ST_START;
            ST_START:     state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (tx_busy) state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!tx_busy) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            tx_data <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_LOAD) begin
                tx_data <= fifo_dout;
            end
        end
    end

    // Strobes decode straight from state so reset removes them without waiting for a clock
    assign fifo_rd_en = (state == ST_LOAD);
    assign tx_start   = (state == ST_START);

`ifdef SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cnt0 <= '0;
            stat_cnt1 <= '0;
        end else begin
            if (accept[0] && stat_cnt0 != '1) stat_cnt0 <= stat_cnt0 + 1'b1;
            if (accept[1] && stat_cnt1 != '1) stat_cnt1 <= stat_cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - self-checking bench for uart_tx_sched with FIFO and transmitter models
module tb_uart_tx_sched;

    localparam int DW = 8;
    localparam int SW = 4;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] ch0_data = '0, ch1_data = '0;
    logic          ch0_valid = 1'b0, ch1_valid = 1'b0;
    logic          ch0_ready, ch1_ready;
    logic [DW-1:0] fifo_din, tx_data;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_wr_en, fifo_rd_en, tx_start;
    logic          fifo_full = 1'b0, fifo_empty = 1'b1, tx_busy = 1'b0;
`ifdef SCHED_STATS_EN
    logic [SW-1:0] stat_cnt0, stat_cnt1;
`endif

    always #5 clk = ~clk;

    uart_tx_sched #(.DATA_SIZE(DW), .STAT_W(SW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch0_data   (ch0_data),
        .ch0_valid  (ch0_valid),
        .ch0_ready  (ch0_ready),
        .ch1_data   (ch1_data),
        .ch1_valid  (ch1_valid),
        .ch1_ready  (ch1_ready),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .fifo_full  (fifo_full),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
`ifdef SCHED_STATS_EN
        .stat_cnt0  (stat_cnt0),
        .stat_cnt1  (stat_cnt1),
`endif
        .tx_data    (tx_data)
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] q_fifo[$];
    logic [DW-1:0] exp_tx[$];
    logic [DW-1:0] wlog[$];
    logic [DW-1:0] slog[$];
    logic [DW-1:0] exp_txd = '0;
    logic [DW-1:0] pat[4] = '{8'hA0, 8'hB0, 8'hA0, 8'hB0};
    int lw = 1;
    int busy_cnt = 0, busy_len = 3;
    int cyc = 0;
    int last_wr_cyc = -1, last_rd_cyc = -1, last_start_cyc = -1;
    int n_wr = 0, n_rd = 0, n_start = 0;
    int m_cnt0 = 0, m_cnt1 = 0;
    logic prev_rd = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_env();
        fifo_empty = (q_fifo.size() == 0);
        fifo_dout  = fifo_empty ? '0 : q_fifo[0];
        tx_busy    = (busy_cnt != 0);
    endtask

    task automatic cycle();
        int g;
        int cur;
        logic ewr, c_wr, c_rd, c_start;
        logic [DW-1:0] c_din;
        @(negedge clk);
        cur = cyc;
        g = -1;
        if (ch0_valid && ch1_valid) g = (lw == 1) ? 0 : 1;
        else if (ch0_valid)         g = 0;
        else if (ch1_valid)         g = 1;
        ewr = (g >= 0) && !fifo_full;
        chk("ch0_ready", ch0_ready, (g == 0) && !fifo_full);
        chk("ch1_ready", ch1_ready, (g == 1) && !fifo_full);
        chk("fifo_wr_en", fifo_wr_en, ewr);
        if (ewr) chk("fifo_din", fifo_din, (g == 0) ? ch0_data : ch1_data);
        chk("start_after_rd", tx_start, prev_rd);
        chk("tx_data_hold", tx_data, exp_txd);
        if (!rst_n) begin
            chk("rst_low_rd", fifo_rd_en, 0);
            chk("rst_low_start", tx_start, 0);
        end
        if (fifo_rd_en) chk("rd_nonempty", q_fifo.size() != 0, 1);
        if (tx_start) begin
            if (exp_tx.size() == 0) chk("tx_unexpected", tx_start, 0);
            else chk("tx_byte", tx_data, exp_tx.pop_front());
            slog.push_back(tx_data);
        end
`ifdef SCHED_STATS_EN
        chk("stat_cnt0", stat_cnt0, m_cnt0);
        chk("stat_cnt1", stat_cnt1, m_cnt1);
`endif
        c_wr = fifo_wr_en; c_din = fifo_din; c_rd = fifo_rd_en; c_start = tx_start;
        @(posedge clk);
        #1;
        cyc++;
        if (c_wr) begin
            q_fifo.push_back(c_din);
            wlog.push_back(c_din);
            last_wr_cyc = cur;
            n_wr++;
            if (g >= 0) lw = g;
            if (g == 0) m_cnt0 = (m_cnt0 == SMAX) ? SMAX : m_cnt0 + 1;
            if (g == 1) m_cnt1 = (m_cnt1 == SMAX) ? SMAX : m_cnt1 + 1;
        end
        if (c_rd && q_fifo.size() > 0) begin
            exp_txd = q_fifo.pop_front();
            exp_tx.push_back(exp_txd);
            last_rd_cyc = cur;
            n_rd++;
        end
        if (c_start) begin
            busy_cnt = busy_len;
            last_start_cyc = cur;
            n_start++;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        prev_rd = c_rd;
        drive_env();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ch0_valid = 1'b0;
        ch1_valid = 1'b0;
        #1;
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
`ifdef SCHED_STATS_EN
        chk("rst_stat0", stat_cnt0, 0);
        chk("rst_stat1", stat_cnt1, 0);
`endif
        lw = 1; exp_txd = '0; busy_cnt = 0; prev_rd = 1'b0;
        exp_tx.delete();
        slog.delete();
        wlog = q_fifo;
        m_cnt0 = 0; m_cnt1 = 0;
        drive_env();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic wait_start(input int limit);
        int s0 = n_start;
        int k = 0;
        while (n_start == s0 && k < limit) begin
            cycle();
            k++;
        end
        chk("start_seen", n_start != s0, 1);
    endtask

    task automatic drain(input int limit);
        int k = 0;
        ch0_valid = 1'b0;
        ch1_valid = 1'b0;
        fifo_full = 1'b0;
        while (k < limit && !(q_fifo.size() == 0 && busy_cnt == 0 && n_rd == n_start)) begin
            cycle();
            k++;
        end
        chk("drain_done", k < limit, 1);
        repeat (3) cycle();
    endtask

    initial begin
        int w, s1, rd0, st0, nw0;
        #2;
        do_reset();

        // single byte on ch0, latency from FIFO non-empty to pop and start
        ch0_valid = 1'b1; ch0_data = 8'h41;
        cycle();
        ch0_valid = 1'b0;
        w = last_wr_cyc;
        chk("single_wr_count", n_wr, 1);
        wait_start(20);
        chk("lat_rd_en", last_rd_cyc, w + 2);
        chk("lat_tx_start", last_start_cyc, w + 3);
        chk("tx_data_41", tx_data, 8'h41);
        drain(100);

        // both channels contending from reset
        do_reset();
        busy_len = 2;
        ch0_valid = 1'b1; ch0_data = 8'hA0;
        ch1_valid = 1'b1; ch1_data = 8'hB0;
        repeat (4) cycle();
        chk("rr_write_count", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) chk("rr_order", wlog[i], pat[i]);

        // full stalls both; afterwards ch0 is next since ch1 won last
        fifo_full = 1'b1;
        nw0 = n_wr;
        repeat (3) cycle();
        chk("full_no_write", n_wr, nw0);
        fifo_full = 1'b0;
        cycle();
        chk("full_resume_count", n_wr, nw0 + 1);
        chk("full_resume_ch0", wlog[wlog.size() - 1], 8'hA0);
        drain(200);

        // two queued bytes with a long transmitter frame
        busy_len = 10;
        rd0 = n_rd; st0 = n_start;
        ch0_valid = 1'b1; ch0_data = 8'h11;
        cycle();
        ch0_data = 8'h22;
        cycle();
        ch0_valid = 1'b0;
        wait_start(20);
        s1 = last_start_cyc;
        chk("frame1_byte", tx_data, 8'h11);
        wait_start(40);
        chk("frame2_gap", last_start_cyc, s1 + 14);
        chk("frame2_byte", tx_data, 8'h22);
        chk("frames_rd_count", n_rd - rd0, 2);
        chk("frames_start_count", n_start - st0, 2);
        drain(100);

        // reset while the transmitter is mid-frame
        ch1_valid = 1'b1; ch1_data = 8'h5C;
        cycle();
        ch1_valid = 1'b0;
        wait_start(20);
        cycle();
        cycle();
        chk("pre_reset_tx_data", tx_data, 8'h5C);
        do_reset();
        busy_len = 3;
        ch1_valid = 1'b1; ch1_data = 8'h77;
        cycle();
        ch1_valid = 1'b0;
        wait_start(20);
        chk("post_reset_byte", tx_data, 8'h77);
        drain(100);

`ifdef SCHED_STATS_EN
        do_reset();
        busy_len = 1;
        ch0_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            ch0_data = DW'(i);
            cycle();
        end
        ch0_valid = 1'b0;
        cycle();
        chk("stat0_saturated", stat_cnt0, 15);
        chk("stat1_idle", stat_cnt1, 0);
        drain(500);
`endif

        // randomized traffic against the queue-based model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            ch0_valid = ($urandom_range(0, 3) == 0);
            ch1_valid = ($urandom_range(0, 3) == 0);
            ch0_data  = DW'($urandom);
            ch1_data  = DW'($urandom);
            fifo_full = ($urandom_range(0, 4) == 0);
            busy_len  = $urandom_range(1, 4);
            cycle();
        end
        drain(20000);
        chk("rand_sent_count", slog.size(), wlog.size());
        for (int i = 0; i < slog.size() && i < wlog.size(); i++) chk("rand_sent_order", slog[i], wlog[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
